// File: rtl/sd_spi_cmd_engine_if.sv
// Bus between the boot sequencer (master) and the SPI-mode SD command
// engine (slave). Carries the command request, divider control, the SPI
// pins and the R1 status return. clk/rst stay outside the interface.
`timescale 1ns/1ps
interface sd_spi_cmd_engine_if;
    logic [6:0]  cmd;
    logic [31:0] cmd_arg;
    logic        start;
    logic        en_clk;
    logic [7:0]  div_clk;
    logic        sclk;
    logic        sclk_fall;
    logic        mosi;
    logic        miso;
    logic        valid_status;
    logic [6:0]  status;
    logic        available;

    modport master (
        output cmd, cmd_arg, start, en_clk, div_clk, miso,
        input  sclk, sclk_fall, mosi, valid_status, status, available
    );

    modport slave (
        input  cmd, cmd_arg, start, en_clk, div_clk, miso,
        output sclk, sclk_fall, mosi, valid_status, status, available
    );
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine.
// Generates sclk from clk with a programmable half-period, serialises one
// 48-bit command frame on mosi (changing on sclk falls), waits for the R1
// response on miso (sampled on sclk rises), reports it as a one-clk status
// pulse and then clocks NRC_BITS trailing sclk periods before going idle.
// Optional feature macro: SD_CRC7_EN -- when defined the frame carries a real
// CRC-7 over {01, index, arg}; otherwise the CRC field is the fixed CMD0
// value 7'h4A (last byte 0x95).
`timescale 1ns/1ps
module sd_spi_cmd_engine #(
    parameter int NCR_MAX  = 8,
    parameter int NRC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sd_spi_cmd_engine_if.slave   bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEND  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RECV  = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;

    localparam int               CNT_W      = 16;
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
    localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(48);
    localparam logic [CNT_W-1:0] RECV_CNT   = CNT_W'(7);
    localparam logic [CNT_W-1:0] NCR_CNT    = CNT_W'(NCR_MAX * 8);
    localparam logic [CNT_W-1:0] NRC_CNT    = CNT_W'(NRC_BITS);

    logic [7:0]       div_cnt_reg;
    logic             sclk_reg;
    logic             sclk_fall_reg;
    logic             mosi_reg;
    logic             valid_reg;
    logic [6:0]       status_reg;
    logic             avail_reg;
    logic [2:0]       state_reg;
    logic [47:0]      frame_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [6:0]       rx_reg;

    logic             half_done;
    logic             rise_evt;
    logic             fall_evt;
    logic [39:0]      crc_msg;
    logic [6:0]       crc7;
    logic             cmd_bit6_unused;

    // Bit 6 of the command bus carries no meaning for the engine.
    assign cmd_bit6_unused = bus.cmd[6];

    // A half-period ends when the counter meets the (live) divider value.
    assign half_done = bus.en_clk && (div_cnt_reg == bus.div_clk);
    assign rise_evt  = half_done && !sclk_reg;
    assign fall_evt  = half_done &&  sclk_reg;

    assign crc_msg = {2'b01, bus.cmd[5:0], bus.cmd_arg};

`ifdef SD_CRC7_EN
    function automatic logic [6:0] crc7_calc(input logic [39:0] msg);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = msg[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ 7'h09;
            end
        end
        return c;
    endfunction
`endif

    // CRC field for the frame being latched.
    always_comb begin
`ifdef SD_CRC7_EN
        crc7 = crc7_calc(crc_msg);
`else
        crc7 = 7'h4A;
`endif
    end

    // sclk is forced low while the clock is disabled; the phase is kept in
    // sclk_reg so the command resumes exactly where it stopped.
    assign bus.sclk         = sclk_reg & bus.en_clk;
    assign bus.sclk_fall    = sclk_fall_reg;
    assign bus.mosi         = mosi_reg;
    assign bus.valid_status = valid_reg;
    assign bus.status       = status_reg;
    assign bus.available    = avail_reg;

    // Free-running sclk divider and the registered fall strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg   <= 8'd0;
            sclk_reg      <= 1'b0;
            sclk_fall_reg <= 1'b0;
        end else begin
            sclk_fall_reg <= fall_evt;
            if (bus.en_clk) begin
                if (half_done) begin
                    sclk_reg    <= ~sclk_reg;
                    div_cnt_reg <= 8'd0;
                end else begin
                    div_cnt_reg <= div_cnt_reg + 8'd1;
                end
            end
        end
    end

    // Command FSM: frame out on falls, response in on rises, trailer, idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            mosi_reg    <= 1'b1;
            valid_reg   <= 1'b0;
            status_reg  <= 7'h00;
            avail_reg   <= 1'b1;
            frame_reg   <= 48'd0;
            bit_cnt_reg <= '0;
            rx_reg      <= 7'h00;
        end else begin
            valid_reg <= 1'b0;
            if (bus.en_clk) begin
                case (state_reg)
                    ST_IDLE: begin
                        mosi_reg <= 1'b1;
                        if (bus.start && avail_reg) begin
                            frame_reg   <= {crc_msg, crc7, 1'b1};
                            bit_cnt_reg <= '0;
                            avail_reg   <= 1'b0;
                            state_reg   <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (fall_evt) begin
                            // The 49th fall ends the full period of bit 0.
                            if (bit_cnt_reg == FRAME_END) begin
                                mosi_reg    <= 1'b1;
                                bit_cnt_reg <= NCR_CNT;
                                state_reg   <= ST_WAIT;
                            end else begin
                                mosi_reg    <= frame_reg[47];
                                frame_reg   <= {frame_reg[46:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + ONE_CNT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        mosi_reg <= 1'b1;
                        if (rise_evt) begin
                            if (!bus.miso) begin
                                bit_cnt_reg <= RECV_CNT;
                                state_reg   <= ST_RECV;
                            end else if (bit_cnt_reg <= ONE_CNT) begin
                                status_reg  <= 7'h7F;
                                valid_reg   <= 1'b1;
                                bit_cnt_reg <= NRC_CNT;
                                state_reg   <= ST_TRAIL;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - ONE_CNT;
                            end
                        end
                    end
                    ST_RECV: begin
                        mosi_reg <= 1'b1;
                        if (rise_evt) begin
                            rx_reg <= {rx_reg[5:0], bus.miso};
                            if (bit_cnt_reg == ONE_CNT) begin
                                status_reg  <= {rx_reg[5:0], bus.miso};
                                valid_reg   <= 1'b1;
                                bit_cnt_reg <= NRC_CNT;
                                state_reg   <= ST_TRAIL;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - ONE_CNT;
                            end
                        end
                    end
                    ST_TRAIL: begin
                        mosi_reg <= 1'b1;
                        if (rise_evt) begin
                            if (bit_cnt_reg <= ONE_CNT) begin
                                avail_reg <= 1'b1;
                                state_reg <= ST_IDLE;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - ONE_CNT;
                            end
                        end
                    end
                    default: begin
                        mosi_reg  <= 1'b1;
                        avail_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Self-checking bench for sd_spi_cmd_engine: divider timing, frame content
// against a frame/CRC reference, R1 capture and timeout, trailer length,
// start-while-busy, clock freeze and mid-response reset.
`timescale 1ns/1ps
module tb_sd_spi_cmd_engine;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_spi_cmd_engine_if bus();

    sd_spi_cmd_engine #(.NCR_MAX(8), .NRC_BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CRC-7 as the remainder of polynomial long division of msg * x^7.
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [6:0] c;
`ifdef SD_CRC7_EN
        c = ref_crc7({2'b01, idx, arg});
`else
        c = 7'h4A;
`endif
        return {2'b01, idx, arg, c, 1'b1};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_sclk"},      bus.sclk,         1'b0);
        check({tag, "_sclk_fall"}, bus.sclk_fall,    1'b0);
        check({tag, "_mosi"},      bus.mosi,         1'b1);
        check({tag, "_valid"},     bus.valid_status, 1'b0);
        check({tag, "_status"},    bus.status,       7'h00);
        check({tag, "_available"}, bus.available,    1'b1);
    endtask

    // Measures one low and one high phase of sclk for divider value d.
    task automatic check_divider(input logic [7:0] d);
        int n, seen, low, high;
        bit strobe_ok;
        bus.div_clk = d;
        n = 0; seen = 0;
        while (seen < 2 && n < 2000) begin
            tick(); n++;
            if (bus.sclk_fall) seen++;
        end
        check("div_sync", seen, 2);
        strobe_ok = 1'b1;
        low = 1; n = 0;
        tick();
        while (bus.sclk === 1'b0 && n < 1000) begin
            if (bus.sclk_fall) strobe_ok = 1'b0;
            low++; tick(); n++;
        end
        if (bus.sclk_fall) strobe_ok = 1'b0;
        high = 1;
        tick();
        while (bus.sclk === 1'b1 && n < 1000) begin
            if (bus.sclk_fall) strobe_ok = 1'b0;
            high++; tick(); n++;
        end
        check("div_low_len",  low,  d + 1);
        check("div_high_len", high, d + 1);
        check("fall_strobe_at_edge", bus.sclk_fall, 1'b1);
        check("fall_strobe_elsewhere", strobe_ok, 1'b1);
        tick();
        check("fall_strobe_single", bus.sclk_fall, 1'b0);
        $display("divider div_clk=%0d low=%0d high=%0d", d, low, high);
    endtask

    // mode 0 normal, 1 start pulse during SEND, 2 en_clk freeze mid-SEND,
    // 3 reset mid-RECV (lead must be small).
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int lead,
                           input logic [7:0] r1_in, input logic [7:0] div, input int mode,
                           output logic [47:0] frame_out);
        logic [47:0] exp_frame, frame_got;
        logic [6:0]  exp_status, got_status;
        logic [7:0]  r1;
        bit          q[$];
        int          falls, vcount, rises_after, cycles;
        bit          seen_valid, done, aborted, prev_sclk, freeze_ok, mosi_ok;

        r1 = r1_in & 8'h7F;
        exp_frame  = ref_frame(idx, arg);
        exp_status = (lead >= 64) ? 7'h7F : r1[6:0];
        for (int i = 0; i < lead; i++) q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) q.push_back(r1[i]);

        falls = 0; vcount = 0; rises_after = 0; cycles = 0;
        seen_valid = 0; done = 0; aborted = 0; mosi_ok = 1;
        frame_got = '0; got_status = '0;

        bus.div_clk = div;
        bus.miso    = 1'b1;
        bus.cmd     = {1'($urandom), idx};
        bus.cmd_arg = arg;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("accept_available_low", bus.available, 1'b0);
        prev_sclk = bus.sclk;

        while (!done && cycles < 8000) begin
            tick(); cycles++;
            bus.start = 1'b0;
            if (seen_valid && !prev_sclk && bus.sclk) rises_after++;
            if (bus.valid_status) begin
                vcount++;
                seen_valid = 1;
                got_status = bus.status;
                if (bus.mosi !== 1'b1) mosi_ok = 0;
            end
            if (bus.available) done = 1;
            if (bus.sclk_fall) begin
                falls++;
                if (falls <= 48) frame_got = {frame_got[46:0], bus.mosi};
                if (falls >= 49) bus.miso = (q.size() > 0) ? q.pop_front() : 1'b1;
                if (mode == 1 && falls == 10) begin
                    bus.cmd     = 7'h3F;
                    bus.cmd_arg = $urandom;
                    bus.start   = 1'b1;
                end
                if (mode == 2 && falls == 20) begin
                    bus.en_clk = 1'b0;
                    freeze_ok = 1;
                    for (int k = 0; k < 20; k++) begin
                        tick(); cycles++;
                        if (bus.sclk !== 1'b0 || bus.sclk_fall !== 1'b0) freeze_ok = 0;
                    end
                    check("freeze_sclk_low", freeze_ok, 1'b1);
                    bus.en_clk = 1'b1;
                end
                if (mode == 3 && falls == 49 + lead + 3) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    bus.miso = 1'b1;
                    check_reset_values("midrecv_rst");
                    check("midrecv_no_valid", vcount, 0);
                    aborted = 1;
                    done = 1;
                end
            end
            prev_sclk = bus.sclk;
        end
        frame_out = frame_got;
        if (aborted) begin
            $display("cmd%0d arg=%08h reset during response, frame=%012h", idx, arg, frame_got);
            return;
        end
        check("cmd_completed", done, 1'b1);
        check("frame", frame_got, exp_frame);
        check("valid_pulses", vcount, 1);
        check("status_at_valid", got_status, exp_status);
        check("status_held", bus.status, exp_status);
        check("trail_rises", rises_after, 8);
        check("mosi_idle_after_frame", mosi_ok && bus.mosi, 1'b1);
        $display("cmd%0d arg=%08h lead=%0d div=%0d mode=%0d frame=%012h status=%02h pulses=%0d",
                 idx, arg, lead, div, mode, frame_got, got_status, vcount);
    endtask

    initial begin
        logic [47:0] fr;
        rst         = 1'b1;
        bus.cmd     = '0;
        bus.cmd_arg = '0;
        bus.start   = 1'b0;
        bus.en_clk  = 1'b0;
        bus.div_clk = 8'd0;
        bus.miso    = 1'b1;
        repeat (3) tick();
        bus.en_clk = 1'b1;
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        check_divider(8'd0);
        check_divider(8'd3);

        // CMD0: 40 00 00 00 00 95, R1 = 0x01 after two idle bytes.
        run_cmd(6'd0, 32'h0, 16, 8'h01, 8'd0, 0, fr);
        check("cmd0_last_byte", fr[7:0], 8'h95);

        // CMD8 with 0x1AA.
        run_cmd(6'd8, 32'h000001AA, 3, 8'h01, 8'd1, 0, fr);
`ifdef SD_CRC7_EN
        check("cmd8_last_byte", fr[7:0], 8'h87);
`else
        check("cmd8_last_byte", fr[7:0], 8'h95);
`endif

        // No response at all: timeout status.
        run_cmd(6'($urandom), $urandom, 80, 8'h00, 8'd0, 0, fr);
        // Response on the very last allowed sample, and one past it.
        run_cmd(6'd55, $urandom, 63, 8'h05, 8'd0, 0, fr);
        run_cmd(6'd17, $urandom, 64, 8'h05, 8'd0, 0, fr);

        // start while busy is ignored; freeze mid-SEND stretches the frame.
        run_cmd(6'd9, $urandom, 5, 8'h00, 8'd1, 1, fr);
        run_cmd(6'd41, $urandom, 4, 8'h7F, 8'd0, 2, fr);

        // Reset in the middle of the response, then a normal command.
        run_cmd(6'd12, $urandom, 2, 8'h3C, 8'd0, 3, fr);
        run_cmd(6'd13, $urandom, 1, 8'h02, 8'd0, 0, fr);

        // Randomized commands.
        for (int t = 0; t < 6; t++) begin
            run_cmd(6'($urandom), $urandom, int'($urandom_range(0, 66)),
                    8'($urandom), 8'($urandom_range(0, 2)), 0, fr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
